// File: rtl/nibble_packer.sv
// nibble_packer
// Scatters 4-bit input lanes into two 32-bit accumulation words (A and B) at
// per-lane nibble positions. Each word is presented with valid/ready once all
// eight of its nibbles have been written.
//
// Build option: define PACKER_PARITY_EN to add the par_a/par_b outputs
// (bit k = XOR of nibble k of the presented word).
//
// Ports:
//   clk, rst_n        clock (posedge) and asynchronous active-low reset
//   in_valid/in_ready input beat handshake
//   nibbles           lane i data = nibbles[i*4 +: 4]
//   lane_en           lane i participates in the beat when 1
//   pos               lane i target nibble index = pos[i*3 +: 3]
//   sel_ab            lane i target word, 0 = A, 1 = B
//   data_a/valid_a/ready_a   completed word A and its handshake
//   data_b/valid_b/ready_b   completed word B and its handshake
//   par_a, par_b      per-nibble parity of data_a/data_b (PACKER_PARITY_EN only)
module nibble_packer #(
  parameter int N_LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*N_LANES-1:0] nibbles,
  input  logic [N_LANES-1:0]   lane_en,
  input  logic [3*N_LANES-1:0] pos,
  input  logic [N_LANES-1:0]   sel_ab,
  output logic [31:0]          data_a,
  output logic                 valid_a,
  input  logic                 ready_a,
  output logic [31:0]          data_b,
  output logic                 valid_b,
  input  logic                 ready_b
`ifdef PACKER_PARITY_EN
  ,
  output logic [7:0]           par_a,
  output logic [7:0]           par_b
`endif
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_a, state_a_next;
  state_t      state_b, state_b_next;
  logic [31:0] acc_a, acc_b;
  logic [31:0] acc_a_wr, acc_b_wr;
  logic [7:0]  mask_a, mask_b;
  logic [7:0]  mask_a_wr, mask_b_wr;
  logic        blocked;
  logic        accept;
  logic        done_a, done_b;
  logic        take_a, take_b;

  // A beat is refused as a whole if any enabled lane points at a word that is
  // still waiting for its consumer. Deliberately independent of in_valid.
  always_comb begin
    blocked = 1'b0;
    for (int i = 0; i < N_LANES; i++) begin
      if (lane_en[i] && ((sel_ab[i] && state_b == HOLD) ||
                         (!sel_ab[i] && state_a == HOLD))) begin
        blocked = 1'b1;
      end
    end
  end

  assign in_ready = !blocked;
  assign accept   = in_valid && in_ready;

  // Merge the beat into copies of both accumulators. Lanes are applied in
  // ascending order, so the highest lane wins when two hit the same nibble.
  always_comb begin
    acc_a_wr  = acc_a;
    acc_b_wr  = acc_b;
    mask_a_wr = mask_a;
    mask_b_wr = mask_b;
    for (int i = 0; i < N_LANES; i++) begin
      if (lane_en[i]) begin
        if (sel_ab[i]) begin
          acc_b_wr[{pos[i*3 +: 3], 2'b00} +: 4] = nibbles[i*4 +: 4];
          mask_b_wr[pos[i*3 +: 3]]              = 1'b1;
        end else begin
          acc_a_wr[{pos[i*3 +: 3], 2'b00} +: 4] = nibbles[i*4 +: 4];
          mask_a_wr[pos[i*3 +: 3]]              = 1'b1;
        end
      end
    end
  end

  assign done_a = accept && (state_a == FILL) && (mask_a_wr == 8'hFF);
  assign done_b = accept && (state_b == FILL) && (mask_b_wr == 8'hFF);
  assign take_a = (state_a == HOLD) && ready_a;
  assign take_b = (state_b == HOLD) && ready_b;

  // FILL/HOLD state registers for both words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_a <= FILL;
      state_b <= FILL;
    end else begin
      state_a <= state_a_next;
      state_b <= state_b_next;
    end
  end

  // Next-state logic: enter HOLD on the completing beat, leave on handshake.
  always_comb begin
    state_a_next = state_a;
    state_b_next = state_b;
    case (state_a)
      FILL:    if (done_a) state_a_next = HOLD;
      HOLD:    if (ready_a) state_a_next = FILL;
      default: state_a_next = FILL;
    endcase
    case (state_b)
      FILL:    if (done_b) state_b_next = HOLD;
      HOLD:    if (ready_b) state_b_next = FILL;
      default: state_b_next = FILL;
    endcase
  end

  assign valid_a = (state_a == HOLD);
  assign valid_b = (state_b == HOLD);

  // Accumulators, fill masks and the presented words. The output word is a
  // separate register so it stays put after the handshake while the next
  // word is being assembled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_a  <= '0;
      acc_b  <= '0;
      mask_a <= '0;
      mask_b <= '0;
      data_a <= '0;
      data_b <= '0;
    end else begin
      if (take_a) begin
        mask_a <= '0;
      end else if (accept && state_a == FILL) begin
        acc_a  <= acc_a_wr;
        mask_a <= mask_a_wr;
      end
      if (take_b) begin
        mask_b <= '0;
      end else if (accept && state_b == FILL) begin
        acc_b  <= acc_b_wr;
        mask_b <= mask_b_wr;
      end
      if (done_a) data_a <= acc_a_wr;
      if (done_b) data_b <= acc_b_wr;
    end
  end

`ifdef PACKER_PARITY_EN
  function automatic logic [7:0] nib_parity(input logic [31:0] w);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = ^w[k*4 +: 4];
    return r;
  endfunction

  // Parity is captured on the same edge as the word it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_a <= '0;
      par_b <= '0;
    end else begin
      if (done_a) par_a <= nib_parity(acc_a_wr);
      if (done_b) par_b <= nib_parity(acc_b_wr);
    end
  end
`endif

endmodule
